// File: rtl/player_shot_ctrl_if.sv
// Interface: player_shot_ctrl_if
//
// Groups the keyboard/player inputs and the shot outputs of player_shot_ctrl.
//   keycode        8   current keyboard keycode
//   player_X       10  player centre X
//   hit            1   collision report for the shot this frame
//   shot_x/shot_y  10  shot position
//   shot_active    1   shot in flight
//   shot_exploding 1   explosion shown at shot position
//   shot_fired     1   one-frame launch pulse
//   ready          1   controller idle, a fire-key edge would launch
// master: the shot controller. slave: the surrounding game logic / bench.
interface player_shot_ctrl_if;
  logic [7:0] keycode;
  logic [9:0] player_X;
  logic       hit;
  logic [9:0] shot_x;
  logic [9:0] shot_y;
  logic       shot_active;
  logic       shot_exploding;
  logic       shot_fired;
  logic       ready;

  modport master (
    input  keycode, player_X, hit,
    output shot_x, shot_y, shot_active, shot_exploding, shot_fired, ready
  );

  modport slave (
    output keycode, player_X, hit,
    input  shot_x, shot_y, shot_active, shot_exploding, shot_fired, ready
  );
endinterface

// File: rtl/player_shot_ctrl.sv
// Module: player_shot_ctrl
//
// Sequences the player's single laser shot, one step per frame: launch on a fire-key
// edge, fly upward, end on hit or at the top, show an explosion after a hit, then
// hold off for a cooldown before the next shot.
//   frame_clk  once-per-frame clock, rising edge
//   Reset      asynchronous, active-high
//   bus        player_shot_ctrl_if.master (key/player/hit in, shot outputs out)
module player_shot_ctrl #(
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter logic [9:0] SHOT_Y_START    = 10'd440,
  parameter logic [9:0] SHOT_Y_MIN      = 10'd0,
  parameter logic [9:0] SHOT_STEP       = 10'd4,
  parameter logic [7:0] EXPLODE_FRAMES  = 8'd8,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd15
) (
  input logic                frame_clk,
  input logic                Reset,
  player_shot_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFly, StHit, StCool} state_e;

  // One extra bit so the top-of-screen limit cannot overflow.
  localparam logic [10:0] TopLimit = {1'b0, SHOT_Y_MIN} + {1'b0, SHOT_STEP};

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       active_q, active_d;
  logic       expl_q, expl_d;
  logic       fired_q, fired_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] key_prev_q;
  logic       fire_edge;

  assign fire_edge = (bus.keycode == FIRE_KEY) && (key_prev_q != FIRE_KEY);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    expl_d   = expl_q;
    fired_d  = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (fire_edge) begin
          x_d      = bus.player_X;
          y_d      = SHOT_Y_START;
          active_d = 1'b1;
          fired_d  = 1'b1;
          state_d  = StFly;
        end
      end
      StFly: begin
        // Hit wins over reaching the top in the same frame.
        if (bus.hit) begin
          active_d = 1'b0;
          expl_d   = 1'b1;
          cnt_d    = EXPLODE_FRAMES - 8'd1;
          state_d  = StHit;
        end else if ({1'b0, y_q} < TopLimit) begin
          // Another step would pass the top: miss, y stays put.
          active_d = 1'b0;
          cnt_d    = COOLDOWN_FRAMES - 8'd1;
          state_d  = StCool;
        end else begin
          y_d = y_q - SHOT_STEP;
        end
      end
      StHit: begin
        if (cnt_q == 8'd0) begin
          expl_d  = 1'b0;
          cnt_d   = COOLDOWN_FRAMES - 8'd1;
          state_d = StCool;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StCool: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = StIdle;
        active_d = 1'b0;
        expl_d   = 1'b0;
        cnt_d    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      x_q        <= 10'd0;
      y_q        <= SHOT_Y_START;
      active_q   <= 1'b0;
      expl_q     <= 1'b0;
      fired_q    <= 1'b0;
      cnt_q      <= 8'd0;
      key_prev_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      active_q   <= active_d;
      expl_q     <= expl_d;
      fired_q    <= fired_d;
      cnt_q      <= cnt_d;
      key_prev_q <= bus.keycode;
    end
  end

  assign bus.shot_x         = x_q;
  assign bus.shot_y         = y_q;
  assign bus.shot_active    = active_q;
  assign bus.shot_exploding = expl_q;
  assign bus.shot_fired     = fired_q;
  assign bus.ready          = (state_q == StIdle);

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Directed bench for player_shot_ctrl: launch, flight to the top, hit and explosion,
// held/repeated keys, ignored hits and asynchronous reset mid-flight.
module tb_player_shot_ctrl;

  logic frame_clk = 1'b0;
  logic Reset;
  int   vectors     = 0;
  int   miscompares = 0;

  player_shot_ctrl_if bus_if ();

  player_shot_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus_if)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset           = 1'b1;
    bus_if.keycode  = 8'h00;
    bus_if.player_X = 10'd320;
    bus_if.hit      = 1'b0;
    repeat (2) tick;
    check_val("rst_ready", bus_if.ready, 1);
    check_val("rst_x", bus_if.shot_x, 0);
    check_val("rst_y", bus_if.shot_y, 440);
    check_val("rst_active", bus_if.shot_active, 0);
    check_val("rst_expl", bus_if.shot_exploding, 0);
    check_val("rst_fired", bus_if.shot_fired, 0);
    Reset = 1'b0;
    tick;

    // Launch.
    bus_if.keycode = 8'h2C;
    tick;
    check_val("l1_fired", bus_if.shot_fired, 1);
    check_val("l1_x", bus_if.shot_x, 320);
    check_val("l1_y", bus_if.shot_y, 440);
    check_val("l1_active", bus_if.shot_active, 1);
    check_val("l1_ready", bus_if.ready, 0);
    bus_if.player_X = 10'd100;
    tick;
    check_val("f1_y", bus_if.shot_y, 436);
    check_val("f1_x", bus_if.shot_x, 320);
    check_val("f1_fired", bus_if.shot_fired, 0);
    tick;
    check_val("f2_y", bus_if.shot_y, 432);

    // Re-press mid-flight is dropped.
    bus_if.keycode = 8'h00;
    tick;
    bus_if.keycode = 8'h2C;
    tick;
    check_val("mid_press_fired", bus_if.shot_fired, 0);
    check_val("mid_press_y", bus_if.shot_y, 424);

    // Fly to the top: 424 -> 0 in 106 steps.
    repeat (106) tick;
    check_val("top_y", bus_if.shot_y, 0);
    check_val("top_active", bus_if.shot_active, 1);
    tick;
    check_val("miss_active", bus_if.shot_active, 0);
    check_val("miss_y", bus_if.shot_y, 0);
    check_val("miss_ready", bus_if.ready, 0);

    // Press during cooldown (2 of the remaining 14 frames).
    bus_if.keycode = 8'h00;
    tick;
    bus_if.keycode = 8'h2C;
    tick;
    check_val("cool_press_fired", bus_if.shot_fired, 0);
    repeat (12) tick;
    check_val("cool_last_ready", bus_if.ready, 0);
    tick;
    check_val("cool_done_ready", bus_if.ready, 1);
    check_val("cool_done_y", bus_if.shot_y, 0);
    check_val("cool_done_active", bus_if.shot_active, 0);

    // Held key in IDLE never fires; hit in IDLE ignored.
    tick;
    check_val("held_fired", bus_if.shot_fired, 0);
    check_val("held_ready", bus_if.ready, 1);
    bus_if.hit = 1'b1;
    tick;
    bus_if.hit = 1'b0;
    check_val("idle_hit_expl", bus_if.shot_exploding, 0);
    check_val("idle_hit_ready", bus_if.ready, 1);

    // Second shot, hit at y=400.
    bus_if.keycode  = 8'h00;
    bus_if.player_X = 10'd320;
    tick;
    bus_if.keycode = 8'h2C;
    tick;
    check_val("l2_fired", bus_if.shot_fired, 1);
    check_val("l2_y", bus_if.shot_y, 440);
    repeat (10) tick;
    check_val("pre_hit_y", bus_if.shot_y, 400);
    bus_if.hit = 1'b1;
    tick;
    bus_if.hit = 1'b0;
    check_val("hit_active", bus_if.shot_active, 0);
    check_val("hit_expl", bus_if.shot_exploding, 1);
    check_val("hit_x", bus_if.shot_x, 320);
    check_val("hit_y", bus_if.shot_y, 400);
    repeat (7) tick;
    check_val("expl_last", bus_if.shot_exploding, 1);
    check_val("expl_last_y", bus_if.shot_y, 400);
    tick;
    check_val("expl_done", bus_if.shot_exploding, 0);
    check_val("expl_done_ready", bus_if.ready, 0);
    repeat (14) tick;
    check_val("hit_cool_last", bus_if.ready, 0);
    tick;
    check_val("hit_cool_done", bus_if.ready, 1);

    // Third shot, asynchronous reset at y=200.
    bus_if.keycode = 8'h00;
    tick;
    bus_if.keycode = 8'h2C;
    tick;
    check_val("l3_fired", bus_if.shot_fired, 1);
    repeat (60) tick;
    check_val("l3_y200", bus_if.shot_y, 200);
    #2;
    Reset = 1'b1;
    #1;
    check_val("async_active", bus_if.shot_active, 0);
    check_val("async_y", bus_if.shot_y, 440);
    check_val("async_x", bus_if.shot_x, 0);
    check_val("async_ready", bus_if.ready, 1);
    #2;
    Reset          = 1'b0;
    bus_if.keycode = 8'h00;
    tick;
    check_val("post_rst_ready", bus_if.ready, 1);
    bus_if.keycode = 8'h2C;
    tick;
    check_val("post_rst_fired", bus_if.shot_fired, 1);
    check_val("post_rst_active", bus_if.shot_active, 1);
    check_val("post_rst_y", bus_if.shot_y, 440);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
